// File: rtl/mpc_pkg.sv
// mpc_pkg: shared types and default bus widths for the multi-project
// IO switch (mpc_switch and its per-side mux).
//   mpc_state_e : switch FSM states
//   MPC_*_W     : default per-macro bus widths for north/east/west sides
package mpc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ACTIVE = 2'd2
    } mpc_state_e;

    localparam int unsigned MPC_N_W = 10;
    localparam int unsigned MPC_E_W = 14;
    localparam int unsigned MPC_W_W = 14;

endpackage

// File: rtl/mpc_side_mux.sv
// mpc_side_mux: combinational N:1 selector for one pad side.
//   bus_o/bus_oe : flattened macro outputs, macro i at [i*WIDTH +: WIDTH]
//   sel          : index of the macro to forward
//   force_zero   : drive all-zero o/oe regardless of sel
//   pad_o/pad_oe : selected slice (next value for the pad registers)
module mpc_side_mux #(
    parameter int unsigned NUM_MACROS = 4,
    parameter int unsigned WIDTH      = 10,
    localparam int unsigned SEL_W     = $clog2(NUM_MACROS)
) (
    input  logic [NUM_MACROS*WIDTH-1:0] bus_o,
    input  logic [NUM_MACROS*WIDTH-1:0] bus_oe,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        force_zero,
    output logic [WIDTH-1:0]            pad_o,
    output logic [WIDTH-1:0]            pad_oe
);

    always_comb begin
        pad_o  = '0;
        pad_oe = '0;
        if (!force_zero) begin
            for (int unsigned i = 0; i < NUM_MACROS; i++) begin
                if (sel == SEL_W'(i)) begin
                    pad_o  = bus_o[i*WIDTH +: WIDTH];
                    pad_oe = bus_oe[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/mpc_switch.sv
// mpc_switch: clocked multi-project IO switch. Routes the north/east/west
// buses of one user macro to the registered pad drive and steers pad inputs
// back to that macro only. Every selection change passes through a
// tri-state blanking window of BLANK_CYCLES so no two macros ever drive
// the pads in the same cycle.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cfg_req_valid/sel/ready    : selection request handshake
//   cfg_done / cfg_err         : one-cycle pulses (selection live / out of range)
//   active_valid/active_sel    : current owner of the pads
//   macro_en                   : one-hot owner enable, zero when unowned
//   north_/east_/west_ o, oe   : flattened macro outputs
//   IO_*_o, IO_*_oe            : registered pad drive
//   IO_*_i                     : pad inputs
//   north_i/east_i/west_i      : per-macro inputs, zero for non-owners
module mpc_switch
    import mpc_pkg::*;
#(
    parameter int unsigned NUM_MACROS   = 4,
    parameter int unsigned N_W          = MPC_N_W,
    parameter int unsigned E_W          = MPC_E_W,
    parameter int unsigned W_W          = MPC_W_W,
    parameter int unsigned BLANK_CYCLES = 4,
    localparam int unsigned SEL_W       = $clog2(NUM_MACROS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_req_valid,
    input  logic [SEL_W-1:0]          cfg_req_sel,
    output logic                      cfg_req_ready,
    output logic                      cfg_done,
    output logic                      cfg_err,
    output logic                      active_valid,
    output logic [SEL_W-1:0]          active_sel,
    output logic [NUM_MACROS-1:0]     macro_en,
    input  logic [NUM_MACROS*N_W-1:0] north_o,
    input  logic [NUM_MACROS*N_W-1:0] north_oe,
    input  logic [NUM_MACROS*E_W-1:0] east_o,
    input  logic [NUM_MACROS*E_W-1:0] east_oe,
    input  logic [NUM_MACROS*W_W-1:0] west_o,
    input  logic [NUM_MACROS*W_W-1:0] west_oe,
    output logic [N_W-1:0]            IO_north_o,
    output logic [N_W-1:0]            IO_north_oe,
    output logic [E_W-1:0]            IO_east_o,
    output logic [E_W-1:0]            IO_east_oe,
    output logic [W_W-1:0]            IO_west_o,
    output logic [W_W-1:0]            IO_west_oe,
    input  logic [N_W-1:0]            IO_north_i,
    input  logic [E_W-1:0]            IO_east_i,
    input  logic [W_W-1:0]            IO_west_i,
    output logic [NUM_MACROS*N_W-1:0] north_i,
    output logic [NUM_MACROS*E_W-1:0] east_i,
    output logic [NUM_MACROS*W_W-1:0] west_i
);

    localparam int unsigned CNT_W = $clog2(BLANK_CYCLES + 1);

    mpc_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      pend_q, pend_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  av_q, av_d;
    logic [NUM_MACROS-1:0] en_q, en_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic accept, in_range, same_sel, change, force_zero;

    logic [N_W-1:0] nxt_north_o, nxt_north_oe;
    logic [E_W-1:0] nxt_east_o, nxt_east_oe;
    logic [W_W-1:0] nxt_west_o, nxt_west_oe;

    assign cfg_req_ready = (state_q != ST_DRAIN);
    assign accept        = cfg_req_valid && cfg_req_ready;
    assign in_range      = 32'(cfg_req_sel) < NUM_MACROS;
    assign same_sel      = (state_q == ST_ACTIVE) && (cfg_req_sel == sel_q);
    assign change        = accept && in_range && !same_sel;
    // Blank in the acceptance cycle too, so the old owner's drive never
    // reaches the pads once a switch has been committed.
    assign force_zero    = (state_q != ST_ACTIVE) || change;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            sel_q   <= '0;
            av_q    <= 1'b0;
            en_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            av_q    <= av_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        av_d    = av_q;
        en_d    = en_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (accept) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (same_sel) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = cfg_req_sel;
                        state_d = ST_DRAIN;
                        av_d    = 1'b0;
                        en_d    = '0;
                        cnt_d   = CNT_W'(BLANK_CYCLES - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                    sel_d   = pend_q;
                    av_d    = 1'b1;
                    en_d    = NUM_MACROS'(1) << pend_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mpc_side_mux #(.NUM_MACROS(NUM_MACROS), .WIDTH(N_W)) u_north (
        .bus_o(north_o), .bus_oe(north_oe), .sel(sel_q), .force_zero(force_zero),
        .pad_o(nxt_north_o), .pad_oe(nxt_north_oe)
    );

    mpc_side_mux #(.NUM_MACROS(NUM_MACROS), .WIDTH(E_W)) u_east (
        .bus_o(east_o), .bus_oe(east_oe), .sel(sel_q), .force_zero(force_zero),
        .pad_o(nxt_east_o), .pad_oe(nxt_east_oe)
    );

    mpc_side_mux #(.NUM_MACROS(NUM_MACROS), .WIDTH(W_W)) u_west (
        .bus_o(west_o), .bus_oe(west_oe), .sel(sel_q), .force_zero(force_zero),
        .pad_o(nxt_west_o), .pad_oe(nxt_west_oe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IO_north_o  <= '0;
            IO_north_oe <= '0;
            IO_east_o   <= '0;
            IO_east_oe  <= '0;
            IO_west_o   <= '0;
            IO_west_oe  <= '0;
        end else begin
            IO_north_o  <= nxt_north_o;
            IO_north_oe <= nxt_north_oe;
            IO_east_o   <= nxt_east_o;
            IO_east_oe  <= nxt_east_oe;
            IO_west_o   <= nxt_west_o;
            IO_west_oe  <= nxt_west_oe;
        end
    end

    always_comb begin
        north_i = '0;
        east_i  = '0;
        west_i  = '0;
        for (int unsigned i = 0; i < NUM_MACROS; i++) begin
            if (av_q && (sel_q == SEL_W'(i))) begin
                north_i[i*N_W +: N_W] = IO_north_i;
                east_i[i*E_W +: E_W]  = IO_east_i;
                west_i[i*W_W +: W_W]  = IO_west_i;
            end
        end
    end

    assign cfg_done     = done_q;
    assign cfg_err      = err_q;
    assign active_valid = av_q;
    assign active_sel   = sel_q;
    assign macro_en     = en_q;

endmodule

// File: tb/tb_mpc_switch.sv
// tb_mpc_switch: two switch instances (4 macros and 3 macros) share one
// stimulus stream; each is compared every cycle against a timeline model
// built from the last committed switch cycle.
module tb_mpc_switch;

    localparam int B = 4;

    logic clk, rst_n;
    logic cfg_req_valid;
    logic [1:0] cfg_req_sel;
    logic [39:0] bn_o, bn_oe;
    logic [55:0] be_o, be_oe, bw_o, bw_oe;
    logic [9:0]  IO_north_i;
    logic [13:0] IO_east_i, IO_west_i;

    logic       rdy[2], done[2], err[2], av[2];
    logic [1:0] asel[2];
    logic [9:0] pn_o[2], pn_oe[2];
    logic [13:0] pe_o[2], pe_oe[2], pw_o[2], pw_oe[2];
    logic [3:0] men0;
    logic [2:0] men1;
    logic [39:0] ni0;
    logic [55:0] ei0, wi0;
    logic [29:0] ni1;
    logic [41:0] ei1, wi1;

    mpc_switch #(.NUM_MACROS(4), .N_W(10), .E_W(14), .W_W(14), .BLANK_CYCLES(B)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_req_valid(cfg_req_valid), .cfg_req_sel(cfg_req_sel),
        .cfg_req_ready(rdy[0]), .cfg_done(done[0]), .cfg_err(err[0]),
        .active_valid(av[0]), .active_sel(asel[0]), .macro_en(men0),
        .north_o(bn_o), .north_oe(bn_oe), .east_o(be_o), .east_oe(be_oe),
        .west_o(bw_o), .west_oe(bw_oe),
        .IO_north_o(pn_o[0]), .IO_north_oe(pn_oe[0]), .IO_east_o(pe_o[0]), .IO_east_oe(pe_oe[0]),
        .IO_west_o(pw_o[0]), .IO_west_oe(pw_oe[0]),
        .IO_north_i(IO_north_i), .IO_east_i(IO_east_i), .IO_west_i(IO_west_i),
        .north_i(ni0), .east_i(ei0), .west_i(wi0)
    );

    mpc_switch #(.NUM_MACROS(3), .N_W(10), .E_W(14), .W_W(14), .BLANK_CYCLES(B)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_req_valid(cfg_req_valid), .cfg_req_sel(cfg_req_sel),
        .cfg_req_ready(rdy[1]), .cfg_done(done[1]), .cfg_err(err[1]),
        .active_valid(av[1]), .active_sel(asel[1]), .macro_en(men1),
        .north_o(bn_o[29:0]), .north_oe(bn_oe[29:0]), .east_o(be_o[41:0]), .east_oe(be_oe[41:0]),
        .west_o(bw_o[41:0]), .west_oe(bw_oe[41:0]),
        .IO_north_o(pn_o[1]), .IO_north_oe(pn_oe[1]), .IO_east_o(pe_o[1]), .IO_east_oe(pe_oe[1]),
        .IO_west_o(pw_o[1]), .IO_west_oe(pw_oe[1]),
        .IO_north_i(IO_north_i), .IO_east_i(IO_east_i), .IO_west_i(IO_west_i),
        .north_i(ni1), .east_i(ei1), .west_i(wi1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: a switch committed at cycle tchg to macro tgt blanks
    // cycles tchg+1..tchg+B, goes live at tchg+B+1 and drives pads from
    // tchg+B+2 onward with the previous cycle's bus values.
    int  nm[2] = '{4, 3};
    bit  has_owner[2];
    int  tchg[2], tgt[2], prev_tgt[2];
    bit  done_nx[2], err_nx[2];
    int  cyc;
    logic [39:0] hn_o, hn_oe;
    logic [55:0] he_o, he_oe, hw_o, hw_oe;

    function automatic bit m_drain(int k);
        return has_owner[k] && cyc > tchg[k] && cyc <= tchg[k] + B;
    endfunction
    function automatic bit m_av(int k);
        return has_owner[k] && cyc > tchg[k] + B;
    endfunction
    function automatic int m_asel(int k);
        return m_av(k) ? tgt[k] : prev_tgt[k];
    endfunction
    function automatic bit m_live(int k);
        return has_owner[k] && cyc > tchg[k] + B + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            has_owner[k] = 0; tchg[k] = 0; tgt[k] = 0; prev_tgt[k] = 0;
            done_nx[k] = 0; err_nx[k] = 0;
        end
    endtask

    task automatic check_outputs(input int k);
        string p;
        logic [63:0] men_k;
        int t;
        p = $sformatf("d%0d c%0d", k, cyc);
        t = tgt[k];
        men_k = (k == 0) ? 64'(men0) : 64'(men1);
        chk({p, " ready"}, 64'(rdy[k]), 64'(!m_drain(k)));
        chk({p, " done"}, 64'(done[k]), 64'(done_nx[k] || (has_owner[k] && cyc == tchg[k] + B + 1)));
        chk({p, " err"}, 64'(err[k]), 64'(err_nx[k]));
        chk({p, " active_valid"}, 64'(av[k]), 64'(m_av(k)));
        chk({p, " active_sel"}, 64'(asel[k]), 64'(m_asel(k)));
        chk({p, " macro_en"}, men_k, m_av(k) ? (64'(1) << t) : 64'(0));
        chk({p, " IO_north_o"}, 64'(pn_o[k]), m_live(k) ? 64'(hn_o[t*10 +: 10]) : 64'(0));
        chk({p, " IO_north_oe"}, 64'(pn_oe[k]), m_live(k) ? 64'(hn_oe[t*10 +: 10]) : 64'(0));
        chk({p, " IO_east_o"}, 64'(pe_o[k]), m_live(k) ? 64'(he_o[t*14 +: 14]) : 64'(0));
        chk({p, " IO_east_oe"}, 64'(pe_oe[k]), m_live(k) ? 64'(he_oe[t*14 +: 14]) : 64'(0));
        chk({p, " IO_west_o"}, 64'(pw_o[k]), m_live(k) ? 64'(hw_o[t*14 +: 14]) : 64'(0));
        chk({p, " IO_west_oe"}, 64'(pw_oe[k]), m_live(k) ? 64'(hw_oe[t*14 +: 14]) : 64'(0));
    endtask

    task automatic check_inputs(input int k);
        string p;
        logic [63:0] en, ee, ew;
        p = $sformatf("d%0d c%0d", k, cyc);
        en = '0; ee = '0; ew = '0;
        for (int i = 0; i < nm[k]; i++) begin
            if (m_av(k) && m_asel(k) == i) begin
                en[i*10 +: 10] = IO_north_i;
                ee[i*14 +: 14] = IO_east_i;
                ew[i*14 +: 14] = IO_west_i;
            end
        end
        chk({p, " north_i"}, (k == 0) ? 64'(ni0) : 64'(ni1), en);
        chk({p, " east_i"}, (k == 0) ? 64'(ei0) : 64'(ei1), ee);
        chk({p, " west_i"}, (k == 0) ? 64'(wi0) : 64'(wi1), ew);
    endtask

    task automatic commit(input int k, input logic v, input logic [1:0] s);
        done_nx[k] = 0;
        err_nx[k]  = 0;
        if (v && !m_drain(k)) begin
            if (int'(s) >= nm[k]) begin
                err_nx[k] = 1;
            end else if (m_av(k) && int'(s) == tgt[k]) begin
                done_nx[k] = 1;
            end else begin
                prev_tgt[k]  = m_asel(k);
                tgt[k]       = int'(s);
                tchg[k]      = cyc;
                has_owner[k] = 1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s);
        for (int k = 0; k < 2; k++) check_outputs(k);
        cfg_req_valid = v;
        cfg_req_sel   = s;
        bn_o  = 40'({$urandom, $urandom});
        bn_oe = 40'({$urandom, $urandom});
        be_o  = 56'({$urandom, $urandom});
        be_oe = 56'({$urandom, $urandom});
        bw_o  = 56'({$urandom, $urandom});
        bw_oe = 56'({$urandom, $urandom});
        IO_north_i = 10'($urandom);
        IO_east_i  = 14'($urandom);
        IO_west_i  = 14'($urandom);
        #1;
        for (int k = 0; k < 2; k++) check_inputs(k);
        for (int k = 0; k < 2; k++) commit(k, v, s);
        hn_o = bn_o; hn_oe = bn_oe;
        he_o = be_o; he_oe = be_oe;
        hw_o = bw_o; hw_oe = bw_oe;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_req_valid = 1'b0;
        cfg_req_sel = '0;
        bn_o = '0; bn_oe = '0; be_o = '0; be_oe = '0; bw_o = '0; bw_oe = '0;
        hn_o = '0; hn_oe = '0; he_o = '0; he_oe = '0; hw_o = '0; hw_oe = '0;
        IO_north_i = '0; IO_east_i = '0; IO_west_i = '0;
        cyc = 0;
        model_reset();
        #2;
        for (int k = 0; k < 2; k++) begin check_outputs(k); check_inputs(k); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        idle(2);
        step(1'b1, 2'd2);          // IDLE -> macro 2
        idle(8);
        step(1'b1, 2'd1);          // macro 2 -> macro 1
        idle(8);
        step(1'b1, 2'd1);          // same selection: no blanking
        idle(3);
        step(1'b1, 2'd3);          // out of range for the 3-macro instance
        idle(8);
        step(1'b1, 2'd2);          // start a switch, then hold sel 0 through DRAIN
        for (int i = 0; i < 12; i++) step(1'b1, 2'd0);
        idle(8);

        step(1'b1, 2'd1);          // reset in the second DRAIN cycle
        step(1'b0, 2'd0);
        rst_n = 1'b0;
        IO_north_i = 10'd25;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin check_outputs(k); check_inputs(k); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        idle(3);

        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mpc_switch.md
# mpc_switch

Parametrised, clocked successor to the combinational multi-project IO mux. It routes the north/east/west pad buses of one of `NUM_MACROS` user macros to the chip pads and steers pad inputs back to that macro only. Selection changes arrive through a valid/ready request. Every change passes through a forced tri-state blanking window, so two macros never drive the pads in the same cycle. The block sits between the macro array and the pad ring.

## Interface
- `NUM_MACROS`, 4: number of macros, 2..16.
- `N_W`, 10: north bus width per macro.
- `E_W`, 14: east bus width per macro.
- `W_W`, 14: west bus width per macro.
- `BLANK_CYCLES`, 4: drain length in cycles, at least 1.
- `SEL_W`, derived: `$clog2(NUM_MACROS)`.

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_req_valid` in 1: selection request valid.
- `cfg_req_sel` in SEL_W: requested macro index.
- `cfg_req_ready` out 1: request may be accepted this cycle.
- `cfg_done` out 1: one-cycle pulse when the new selection is live.
- `cfg_err` out 1: one-cycle pulse for a rejected out-of-range request.
- `active_valid` out 1: a macro currently owns the pads.
- `active_sel` out SEL_W: index of the owning macro.
- `macro_en` out NUM_MACROS: one-hot enable for the owning macro; all zero when none owns the pads.
- `north_o`, `north_oe` in NUM_MACROS*N_W: macro north outputs, flattened, macro i at slice [i*N_W +: N_W].
- `east_o`, `east_oe` in NUM_MACROS*E_W: macro east outputs, flattened the same way.
- `west_o`, `west_oe` in NUM_MACROS*W_W: macro west outputs, flattened the same way.
- `IO_north_o`, `IO_north_oe` out N_W: north pad drive, registered.
- `IO_east_o`, `IO_east_oe` out E_W: east pad drive, registered.
- `IO_west_o`, `IO_west_oe` out W_W: west pad drive, registered.
- `IO_north_i` in N_W, `IO_east_i` in E_W, `IO_west_i` in W_W: pad inputs.
- `north_i` out NUM_MACROS*N_W, `east_i` out NUM_MACROS*E_W, `west_i` out NUM_MACROS*W_W: per-macro inputs.

## Operation
- States:
  - IDLE: reset state, no owner.
  - DRAIN: blanking window, counting BLANK_CYCLES.
  - ACTIVE: one macro owns the pads.
- `cfg_req_ready` = (state != DRAIN). A request is accepted on valid && ready.
- Accepted request with `cfg_req_sel >= NUM_MACROS`:
  - `cfg_err` pulses in the next cycle.
  - State, selection and pads are unchanged.
- Accepted request in ACTIVE with `cfg_req_sel == active_sel`:
  - no-op, no blanking.
  - `cfg_done` pulses in the next cycle.
- Any other valid accepted request, from IDLE or ACTIVE:
  - latch the selection into a pending register.
  - go to DRAIN and clear `active_valid` and `macro_en`.
  - load the counter with BLANK_CYCLES-1.
- DRAIN:
  - decrement the counter each cycle.
  - at zero, move to ACTIVE, load `active_sel` from the pending register, set `active_valid`, set `macro_en[sel]`.
- Pad register input:
  - all zeros (o and oe) when state != ACTIVE or a changing request is accepted this cycle.
  - otherwise the `active_sel` slice of each `*_o`/`*_oe` bus.
- Macro input `*_i[i]` is combinational: the pad input when `active_valid && active_sel == i`, else 0.
- Counter width is `$clog2(BLANK_CYCLES+1)`. Index comparison is unsigned.

## Timing
- Reset values: state IDLE, `active_valid` 0, `active_sel` 0, `macro_en` 0, `cfg_done` 0, `cfg_err` 0, all `IO_*_o`/`IO_*_oe` 0.
- `cfg_req_ready` is 1 in reset/IDLE.
- Changing request accepted at the edge ending cycle t:
  - pads read 0 in cycles t+1 through t+BLANK_CYCLES+1.
  - DRAIN covers cycles t+1 through t+BLANK_CYCLES.
  - `active_*` and `macro_en` update at the edge ending cycle t+BLANK_CYCLES.
  - `cfg_done` is high in cycle t+BLANK_CYCLES+1.
  - new macro drive is visible on the pads from cycle t+BLANK_CYCLES+2.
- Requests asserted during DRAIN are not accepted. The requester holds them.
- Reset asserted mid-DRAIN or mid-ACTIVE:
  - immediate return to reset values.
  - the pending selection is discarded.

## Structure
- Package `mpc_pkg`:
  - state enum `mpc_state_e`.
  - default width constants `MPC_N_W`, `MPC_E_W`, `MPC_W_W`.
- Sub-module `mpc_side_mux`:
  - parametrised by width and NUM_MACROS.
  - combinational N:1 selection of o/oe, with force-zero.
  - instantiated once per side.
- `mpc_switch` holds the FSM, counter, pad registers and input steering.

## Test plan
- Reset; after reset, request sel 2 with BLANK_CYCLES=4 -> `cfg_done` in the 5th cycle after acceptance; pads equal macro 2 drive from the 6th; `macro_en` = 4'b0100.
- ACTIVE sel 2, request sel 1 -> pads zero for 5 cycles, never macro 2 and macro 1 in the same cycle; `east_i` slice 2 zero from the switch edge.
- ACTIVE sel 1, request sel 1 -> pads uninterrupted; `cfg_done` the next cycle.
- NUM_MACROS=3, request sel 3 -> `cfg_err` for one cycle; selection and pads unchanged.
- Hold `cfg_req_valid` with sel 0 through DRAIN -> `cfg_req_ready` 0 in DRAIN; accepted on the first ACTIVE cycle.
- `rst_n` low in the 2nd DRAIN cycle -> all outputs zero asynchronously; IDLE after release; `IO_north_i`=25 reaches no macro.
